// File: rtl/hssaer_pkg.sv
// hssaer_pkg: symbol codes, sequencer state encoding and symbol classification for the HSSAER receive path
package hssaer_pkg;
  localparam logic [2:0] SYM_SYNC = 3'd4;
  localparam logic [2:0] SYM_INVALID = 3'b111;
  localparam logic [2:0] SYM_DATA_MAX = 3'd3;
  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_TERM = 2'd3;
  function automatic logic sym_bad(input logic [2:0] d, input logic e);
    return e || (d inside {3'd5, 3'd6, SYM_INVALID});
  endfunction
  function automatic logic sym_is_data(input logic [2:0] d, input logic e);
    return !e && d <= SYM_DATA_MAX;
  endfunction
  function automatic logic sym_is_sync(input logic [2:0] d, input logic e);
    return !e && d == SYM_SYNC;
  endfunction
endpackage

// File: rtl/hssaer_rx_frame_seq_if.sv
// hssaer_rx_frame_seq_if: valid/ready event word channel from the sequencer to the HPU input path
//   evt_data  assembled event word (head of buffer)
//   evt_valid buffer non-empty
//   evt_ready consumer accepts head when evt_valid & evt_ready
interface hssaer_rx_frame_seq_if #(parameter int DATA_W = 32) ();
  logic [DATA_W-1:0] evt_data;
  logic evt_valid;
  logic evt_ready;
  modport master(output evt_data, output evt_valid, input evt_ready);
  modport slave(input evt_data, input evt_valid, output evt_ready);
endinterface

// File: rtl/hssaer_evt_fifo2.sv
// hssaer_evt_fifo2: 2-entry valid/ready buffer with full flag for drop detection
//   clk, _rst   clock, async active-low reset
//   push, din   write request and word (ignored when full unless popping the same cycle)
//   ready       consumer ready; pop = valid & ready
//   dout, valid head word, non-empty
//   full        both entries occupied
module hssaer_evt_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full
);
  logic [DATA_W-1:0] mem [2];
  logic wp, rp, pop, wr;
  logic [1:0] cnt;
  assign valid = cnt != 2'd0;
  assign full = cnt[1];
  assign pop = valid & ready;
  // when full, wp == rp, so a same-cycle push overwrites the slot being popped
  assign wr = push & (~full | pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge _rst)
    if (!_rst) begin
      mem <= '{default: '0};
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (wr) mem[wp] <= din;
      wp <= wp ^ wr;
      rp <= rp ^ pop;
      cnt <= cnt + 2'(wr) - 2'(pop);
    end
endmodule

// File: rtl/hssaer_rx_frame_seq.sv
// hssaer_rx_frame_seq: locks onto SYNC delimiters, assembles dibit frames into event words, counts errors/drops
//   clk, _rst            clock, async active-low reset
//   enable               0 forces HUNT
//   sym_d, sym_st, sym_err  decoded symbol stream
//   evt                  event word channel (master)
//   locked               state is IDLE/DATA/TERM
//   err_cnt, drop_cnt    saturating status counters; clr_cnt clears both
module hssaer_rx_frame_seq
  import hssaer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 _rst,
  input  logic                 enable,
  input  logic [2:0]           sym_d,
  input  logic                 sym_st,
  input  logic                 sym_err,
  hssaer_rx_frame_seq_if.master evt,
  output logic                 locked,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  input  logic                 clr_cnt
);
  localparam logic [5:0] NSYM = 6'(DATA_W / 2);
  logic [1:0] st, st_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [5:0] idx, idx_n;
  logic [15:0] tcnt, tcnt_n;
  logic err_inc, push, full, drop_inc, bad, is_data, is_sync;
  assign bad = sym_bad(sym_d, sym_err);
  assign is_data = sym_is_data(sym_d, sym_err);
  assign is_sync = sym_is_sync(sym_d, sym_err);
  assign locked = st != ST_HUNT;
  assign drop_inc = push & full & ~(evt.evt_valid & evt.evt_ready);
  always_comb begin
    st_n = st;
    sh_n = sh;
    idx_n = idx;
    tcnt_n = '0;
    err_inc = 1'b0;
    push = 1'b0;
    if (!enable) st_n = ST_HUNT;
    else if (sym_st)
      case (st)
        ST_HUNT: st_n = is_sync ? ST_IDLE : ST_HUNT;
        ST_IDLE:
          if (is_data) begin
            sh_n = DATA_W'(sym_d[1:0]);
            idx_n = 6'd1;
            st_n = (NSYM == 6'd1) ? ST_TERM : ST_DATA;
          end else if (bad) begin
            err_inc = 1'b1;
            st_n = ST_HUNT;
          end
        ST_DATA:
          if (is_data) begin
            sh_n = (sh << 2) | DATA_W'(sym_d[1:0]);
            idx_n = idx + 6'd1;
            st_n = (idx_n == NSYM) ? ST_TERM : ST_DATA;
          end else begin
            err_inc = 1'b1;
            st_n = ST_HUNT;
          end
        default:
          if (is_sync) begin
            push = 1'b1;
            st_n = ST_IDLE;
          end else begin
            err_inc = 1'b1;
            st_n = ST_HUNT;
          end
      endcase
    else if (st == ST_DATA || st == ST_TERM) begin
      if (tcnt == 16'(TIMEOUT - 1)) begin
        err_inc = 1'b1;
        st_n = ST_HUNT;
      end else tcnt_n = tcnt + 16'd1;
    end
  end
  always_ff @(posedge clk or negedge _rst)
    if (!_rst) begin
      st <= ST_HUNT;
      sh <= '0;
      idx <= '0;
      tcnt <= '0;
      err_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      st <= st_n;
      sh <= sh_n;
      idx <= idx_n;
      tcnt <= tcnt_n;
      err_cnt <= clr_cnt ? '0 : (err_inc && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
      drop_cnt <= clr_cnt ? '0 : (drop_inc && !(&drop_cnt)) ? drop_cnt + 1'b1 : drop_cnt;
    end
  hssaer_evt_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk  (clk),
    ._rst (_rst),
    .push (push),
    .din  (sh),
    .ready(evt.evt_ready),
    .dout (evt.evt_data),
    .valid(evt.evt_valid),
    .full (full)
  );
endmodule

// File: tb/tb_hssaer_rx_frame_seq.sv
// tb_hssaer_rx_frame_seq: directed bench for the frame sequencer (32-bit default instance and a small 8-bit/TIMEOUT=10/4-bit-counter instance)
module tb_hssaer_rx_frame_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en0 = 1'b0, st0 = 1'b0, se0 = 1'b0, clr0 = 1'b0;
  logic en1 = 1'b0, st1 = 1'b0, se1 = 1'b0, clr1 = 1'b0;
  logic [2:0] sd0 = 3'd0, sd1 = 3'd0;
  logic lk0, lk1;
  logic [15:0] err0, drop0;
  logic [3:0] err1, drop1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  hssaer_rx_frame_seq_if #(.DATA_W(32)) if0 ();
  hssaer_rx_frame_seq_if #(.DATA_W(8)) if1 ();
  hssaer_rx_frame_seq dut0 (
    .clk(clk), ._rst(rst_n), .enable(en0), .sym_d(sd0), .sym_st(st0), .sym_err(se0),
    .evt(if0.master), .locked(lk0), .err_cnt(err0), .drop_cnt(drop0), .clr_cnt(clr0)
  );
  hssaer_rx_frame_seq #(.DATA_W(8), .TIMEOUT(10), .CNT_W(4)) dut1 (
    .clk(clk), ._rst(rst_n), .enable(en1), .sym_d(sd1), .sym_st(st1), .sym_err(se1),
    .evt(if1.master), .locked(lk1), .err_cnt(err1), .drop_cnt(drop1), .clr_cnt(clr1)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic s0(input logic [2:0] d, input logic e = 1'b0);
    sd0 = d; se0 = e; st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0; se0 = 1'b0;
  endtask
  task automatic s1(input logic [2:0] d, input logic e = 1'b0);
    sd1 = d; se1 = e; st1 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0; se1 = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic data0(input int n);
    for (int i = 0; i < n; i++) s0(3'(3 - (i % 4)));
  endtask
  task automatic word0(input logic [31:0] w);
    for (int i = 0; i < 16; i++) s0({1'b0, w[31-2*i -: 2]});
  endtask
  initial begin
    if0.evt_ready = 1'b0;
    if1.evt_ready = 1'b0;
    idle(2);
    chk("rst_valid", if0.evt_valid, 0);
    chk("rst_data", if0.evt_data, 0);
    chk("rst_locked", lk0, 0);
    chk("rst_err", err0, 0);
    chk("rst_drop", drop0, 0);
    rst_n = 1'b1;
    en0 = 1'b1;
    if0.evt_ready = 1'b1;
    idle(1);
    s0(3'd4);
    chk("lock_on_sync", lk0, 1);
    data0(16);
    chk("no_valid_before_term", if0.evt_valid, 0);
    s0(3'd4);
    chk("frame_valid_lat1", if0.evt_valid, 1);
    chk("frame_data", if0.evt_data, 64'hE4E4E4E4);
    chk("frame_err", err0, 0);
    chk("frame_locked", lk0, 1);
    idle(1);
    chk("frame_drained", if0.evt_valid, 0);
    data0(5);
    s0(3'd4);
    chk("short_err", err0, 1);
    chk("short_unlocked", lk0, 0);
    s0(3'd4);
    chk("short_relock", lk0, 1);
    chk("short_no_word", if0.evt_valid, 0);
    data0(17);
    chk("long_err", err0, 2);
    chk("long_hunt", lk0, 0);
    chk("long_no_word", if0.evt_valid, 0);
    s0(3'd4);
    word0(32'hA5C3_0F1E);
    s0(3'd4);
    chk("long_next_valid", if0.evt_valid, 1);
    chk("long_next_data", if0.evt_data, 64'hA5C30F1E);
    idle(1);
    if0.evt_ready = 1'b0;
    word0(32'h1234_5678); s0(3'd4);
    word0(32'h9ABC_DEF0); s0(3'd4);
    word0(32'h0F0F_0F0F); s0(3'd4);
    chk("bp_drop", drop0, 1);
    chk("bp_err", err0, 2);
    chk("bp_locked", lk0, 1);
    idle(3);
    chk("bp_hold_valid", if0.evt_valid, 1);
    chk("bp_hold_data", if0.evt_data, 64'h12345678);
    if0.evt_ready = 1'b1;
    idle(1);
    chk("bp_second", if0.evt_data, 64'h9ABCDEF0);
    chk("bp_second_valid", if0.evt_valid, 1);
    idle(1);
    chk("bp_empty", if0.evt_valid, 0);
    if0.evt_ready = 1'b0;
    word0(32'h1111_2222); s0(3'd4);
    word0(32'h3333_4444); s0(3'd4);
    word0(32'h5555_6666);
    if0.evt_ready = 1'b1;
    s0(3'd4);
    chk("pp_no_drop", drop0, 1);
    chk("pp_head", if0.evt_data, 64'h33334444);
    idle(1);
    chk("pp_third", if0.evt_data, 64'h55556666);
    chk("pp_third_valid", if0.evt_valid, 1);
    idle(1);
    chk("pp_empty", if0.evt_valid, 0);
    data0(5);
    en0 = 1'b0;
    idle(1);
    chk("dis_hunt", lk0, 0);
    chk("dis_no_err", err0, 2);
    en0 = 1'b1;
    s0(3'd4);
    chk("dis_relock", lk0, 1);
    clr0 = 1'b1;
    idle(1);
    clr0 = 1'b0;
    chk("clr_err", err0, 0);
    chk("clr_drop", drop0, 0);
    en1 = 1'b1;
    if1.evt_ready = 1'b1;
    s1(3'd4);
    s1(3'd3); s1(3'd2); s1(3'd1); s1(3'd0);
    idle(9);
    chk("to_9_no_err", err1, 0);
    chk("to_9_locked", lk1, 1);
    idle(1);
    chk("to_10_err", err1, 1);
    chk("to_10_hunt", lk1, 0);
    s1(3'd4);
    s1(3'd3); s1(3'd2); s1(3'd1);
    idle(9);
    s1(3'd0);
    idle(9);
    s1(3'd4);
    chk("to_cont_err", err1, 1);
    chk("to_cont_valid", if1.evt_valid, 1);
    chk("to_cont_data", if1.evt_data, 64'hE4);
    for (int i = 0; i < 14; i++) begin
      s1(3'd4);
      s1(3'd7);
    end
    chk("sat_reach", err1, 4'hF);
    s1(3'd4);
    s1(3'd2, 1'b1);
    chk("sat_hold", err1, 4'hF);
    s1(3'd4);
    clr1 = 1'b1;
    s1(3'd7);
    clr1 = 1'b0;
    chk("clr_beats_inc", err1, 0);
    s1(3'd7);
    chk("hunt_bad_ignored", err1, 0);
    s1(3'd4);
    s1(3'd5);
    chk("sym5_err", err1, 1);
    if0.evt_ready = 1'b0;
    word0(32'hDEAD_BEEF); s0(3'd4);
    word0(32'hCAFE_F00D); s0(3'd4);
    data0(3);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", if0.evt_valid, 0);
    chk("arst_data", if0.evt_data, 0);
    chk("arst_locked", lk0, 0);
    chk("arst_err1", err1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
